// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port of the memory stage.
// master = memory stage (issues requests), slave = data memory.
interface mem_stage_if #(
  parameter int N = 4
) ();
  logic         req;
  logic         we;
  logic [N-1:0] addr;
  logic [N-1:0] wdata;
  logic         ack;
  logic [N-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory stage: unpacks the EX/MEM buffer, runs loads/stores over a req/ack port, feeds WB.
// Optional forwarding outputs are enabled by defining MEM_FWD_EN.
module mem_stage #(
  parameter int N  = 4,
  parameter int BW = 2*N+24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          in_valid_i,
  input  logic [BW-1:0] in_buffer_i,
  output logic          stall_o,
  mem_stage_if.master   mem,
  output logic          wb_valid_o,
  output logic [N-1:0]  wb_result_o,
  output logic [3:0]    wb_rc_o,
  output logic          wb_reg_write_o,
  output logic [2:0]    wb_flags_o
`ifdef MEM_FWD_EN
  ,
  output logic          fwd_valid_o,
  output logic [3:0]    fwd_rc_o,
  output logic [N-1:0]  fwd_data_o
`endif
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e state_q, state_d;

  // Buffer fields
  logic [N-1:0] f_rd3, f_alu;
  logic [3:0]   f_rc;
  logic         f_reg_write, f_mem_to_reg, f_mem_write;
  logic [2:0]   f_flags;
  logic         f_is_mem;
  logic         unused_fields;

  assign f_rd3        = in_buffer_i[N-1:0];
  assign f_rc         = in_buffer_i[N+3:N];
  assign f_reg_write  = in_buffer_i[N+12];
  assign f_mem_to_reg = in_buffer_i[N+13];
  assign f_mem_write  = in_buffer_i[N+14];
  assign f_flags      = {in_buffer_i[N+15], in_buffer_i[N+16], in_buffer_i[N+17]};
  assign f_alu        = in_buffer_i[2*N+17:N+18];
  assign f_is_mem     = f_mem_write | f_mem_to_reg;
  assign unused_fields = ^{in_buffer_i[N+11:N+4], in_buffer_i[BW-1:2*N+18]};

  logic         mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [N-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic         wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
  logic [N-1:0] wb_result_q, wb_result_d;
  logic [3:0]   wb_rc_q, wb_rc_d, cap_rc_q, cap_rc_d;
  logic [2:0]   wb_flags_q, wb_flags_d, cap_flags_q, cap_flags_d;
  logic         cap_reg_write_q, cap_reg_write_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      case (state_q)
        IDLE:    if (in_valid_i && f_is_mem) state_d = ACCESS;
        ACCESS:  if (mem.ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    wb_valid_d      = en_i ? 1'b0 : wb_valid_q;
    wb_result_d     = wb_result_q;
    wb_rc_d         = wb_rc_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_flags_d      = wb_flags_q;
    cap_rc_d        = cap_rc_q;
    cap_reg_write_d = cap_reg_write_q;
    cap_flags_d     = cap_flags_q;
    if (en_i) begin
      case (state_q)
        IDLE: begin
          if (in_valid_i && f_is_mem) begin
            // memWrite wins over memToReg when both are set
            mem_req_d       = 1'b1;
            mem_we_d        = f_mem_write;
            mem_addr_d      = f_alu;
            mem_wdata_d     = f_rd3;
            cap_rc_d        = f_rc;
            cap_reg_write_d = f_reg_write;
            cap_flags_d     = f_flags;
          end else if (in_valid_i) begin
            wb_valid_d     = 1'b1;
            wb_result_d    = f_alu;
            wb_rc_d        = f_rc;
            wb_reg_write_d = f_reg_write;
            wb_flags_d     = f_flags;
          end
        end
        ACCESS: begin
          if (mem.ack) begin
            // The held address is the alu result, so stores write it back from there
            mem_req_d      = 1'b0;
            wb_valid_d     = 1'b1;
            wb_result_d    = mem_we_q ? mem_addr_q : mem.rdata;
            wb_rc_d        = cap_rc_q;
            wb_reg_write_d = cap_reg_write_q;
            wb_flags_d     = cap_flags_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      wb_valid_q      <= 1'b0;
      wb_result_q     <= '0;
      wb_rc_q         <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_flags_q      <= '0;
      cap_rc_q        <= '0;
      cap_reg_write_q <= 1'b0;
      cap_flags_q     <= '0;
    end else begin
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      wb_valid_q      <= wb_valid_d;
      wb_result_q     <= wb_result_d;
      wb_rc_q         <= wb_rc_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_flags_q      <= wb_flags_d;
      cap_rc_q        <= cap_rc_d;
      cap_reg_write_q <= cap_reg_write_d;
      cap_flags_q     <= cap_flags_d;
    end
  end

  assign stall_o        = (state_q == ACCESS);
  assign mem.req        = mem_req_q;
  assign mem.we         = mem_we_q;
  assign mem.addr       = mem_addr_q;
  assign mem.wdata      = mem_wdata_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_result_o    = wb_result_q;
  assign wb_rc_o        = wb_rc_q;
  assign wb_reg_write_o = wb_reg_write_q;
  assign wb_flags_o     = wb_flags_q;

`ifdef MEM_FWD_EN
  logic         fwd_valid_q;
  logic [3:0]   fwd_rc_q;
  logic [N-1:0] fwd_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_valid_q <= 1'b0;
      fwd_rc_q    <= '0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= wb_valid_d & wb_reg_write_d;
      fwd_rc_q    <= wb_rc_d;
      fwd_data_q  <= wb_result_d;
    end
  end

  assign fwd_valid_o = fwd_valid_q;
  assign fwd_rc_o    = fwd_rc_q;
  assign fwd_data_o  = fwd_data_q;
`endif

endmodule
